sfx_scheduler: RTL and testbench

Schedules game sound-effect requests onto the single audio voice of the audio processing unit. Up to four event sources (e.g. hit, jump, pickup, death) raise level requests. The block edge-detects and queues them, picks one by fixed priority, and fires a one-cycle trigger plus a voice select into the audio unit. It then holds the voice for a per-effect duration counted in frames, followed by a short silent gap. Higher-priority effects preempt lower-priority ones; discarded events are flagged.

---
 rtl/sfx_scheduler_if.sv | 23 ++
 rtl/sfx_scheduler.sv | 135 +++++++++++++
 tb/tb_sfx_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sfx_scheduler_if.sv
// Sound-effect scheduler bus: event requests and frame tick in,
// audio-voice trigger/select and status out.
interface sfx_scheduler_if;
  logic [3:0] req;
  logic       frame_end;
  logic       trigger;
  logic [1:0] voice_sel;
  logic [3:0] grant;
  logic       active;
  logic       dropped;

  // Event/game side drives requests and frame tick
  modport master (
    output req, frame_end,
    input  trigger, voice_sel, grant, active, dropped
  );

  // Scheduler side
  modport slave (
    input  req, frame_end,
    output trigger, voice_sel, grant, active, dropped
  );
endinterface

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound-effect scheduler for a single audio voice.
// Edge-detects level requests into a pending set, grants the lowest index,
// plays it for a per-effect frame count, then inserts a silent gap.
// Lower-index requests preempt a playing effect; discarded events pulse dropped.
module sfx_scheduler #(
  parameter int unsigned DUR0       = 30,
  parameter int unsigned DUR1       = 16,
  parameter int unsigned DUR2       = 8,
  parameter int unsigned DUR3       = 4,
  parameter int unsigned GAP_FRAMES = 2
) (
  input  logic           clk,
  input  logic           reset,
  sfx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;

  state_t     state_q;
  logic [3:0] req_q;
  logic [3:0] pending_q, pending_d;
  logic [7:0] cnt_q;
  logic [7:0] gcnt_q;
  logic [1:0] voice_sel_q;
  logic [3:0] grant_q;
  logic       trigger_q;
  logic       active_q;
  logic       dropped_q;

  logic [3:0] req_edge;
  logic [3:0] own;
  logic [3:0] clear;
  logic [1:0] sel_idx;
  logic       pend_any;
  logic       preempt;
  logic       take;
  logic       drop_d;

  // Play length per effect; a zero length still plays one frame
  function automatic logic [7:0] dur_of(input logic [1:0] idx);
    logic [7:0] d;
    case (idx)
      2'd0:    d = 8'(DUR0);
      2'd1:    d = 8'(DUR1);
      2'd2:    d = 8'(DUR2);
      default: d = 8'(DUR3);
    endcase
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  // Edge detect, priority pick, preemption and discard decisions
  always_comb begin
    req_edge = bus.req & ~req_q;
    own      = (state_q == START || state_q == PLAY) ? (4'b0001 << voice_sel_q) : 4'b0000;
    sel_idx  = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (pending_q[i]) sel_idx = 2'(i);
    pend_any = |pending_q;
    preempt  = (state_q == PLAY) && pend_any && (sel_idx < voice_sel_q);
    take     = ((state_q == IDLE) && pend_any) || preempt;
    clear    = take ? (4'b0001 << sel_idx) : 4'b0000;
    // Re-triggering the effect that owns the voice is discarded, not queued
    pending_d = (pending_q | (req_edge & ~own)) & ~clear;
    drop_d    = (|(req_edge & pending_q)) | (|(req_edge & own)) | preempt;
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= bus.req;  // a level held through reset yields no edge
      pending_q   <= 4'b0000;
      cnt_q       <= 8'd0;
      gcnt_q      <= 8'd0;
      voice_sel_q <= 2'd0;
      grant_q     <= 4'b0000;
      trigger_q   <= 1'b0;
      active_q    <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      req_q     <= bus.req;
      pending_q <= pending_d;
      dropped_q <= drop_d;
      trigger_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            voice_sel_q <= sel_idx;
            grant_q     <= 4'b0001 << sel_idx;
            cnt_q       <= dur_of(sel_idx);
            trigger_q   <= 1'b1;
            active_q    <= 1'b1;
            state_q     <= START;
          end
        end
        START: state_q <= PLAY;  // frame ticks are ignored here
        PLAY: begin
          if (preempt) begin
            voice_sel_q <= sel_idx;
            grant_q     <= 4'b0001 << sel_idx;
            cnt_q       <= dur_of(sel_idx);
            trigger_q   <= 1'b1;
            state_q     <= START;
          end else if (bus.frame_end) begin
            if (cnt_q == 8'd1) begin
              gcnt_q   <= 8'(GAP_FRAMES);
              grant_q  <= 4'b0000;
              active_q <= 1'b0;
              state_q  <= GAP;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        GAP: begin
          // gcnt is zero on entry only when no gap is configured
          if (gcnt_q == 8'd0) begin
            state_q <= IDLE;
          end else if (bus.frame_end) begin
            gcnt_q <= gcnt_q - 8'd1;
            if (gcnt_q == 8'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.trigger   = trigger_q;
  assign bus.voice_sel = voice_sel_q;
  assign bus.grant     = grant_q;
  assign bus.active    = active_q;
  assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler: a per-cycle vector table on the default
// instance plus hand sequences for priority, reset and zero-length corners.
module tb_sfx_scheduler;

  logic clk;
  logic reset;

  sfx_scheduler_if ifa();
  sfx_scheduler_if ifb();

  sfx_scheduler dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  sfx_scheduler #(.DUR3(0), .GAP_FRAMES(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {trigger, voice_sel, grant, active, dropped}
  logic [8:0] outa, outb;
  assign outa = {ifa.trigger, ifa.voice_sel, ifa.grant, ifa.active, ifa.dropped};
  assign outb = {ifb.trigger, ifb.voice_sel, ifb.grant, ifb.active, ifb.dropped};

  typedef struct {
    int         rep;
    logic [3:0] req;
    logic       fe;
    logic [8:0] exp;
  } vec_t;

  int nerr = 0;
  int nchk = 0;

  function automatic vec_t mk(int rep, logic [3:0] rq, logic fe, logic tr,
                              logic [1:0] vs, logic [3:0] gn, logic ac, logic dr);
    vec_t v;
    v.rep = rep; v.req = rq; v.fe = fe;
    v.exp = {tr, vs, gn, ac, dr};
    return v;
  endfunction

  task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got t/vs/g/a/d=%b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    int   ntrig, t1, t2, vs1, vs2, g1, ndrop;

    // Single request, gap, preemption, coalescing, no resume of effect 3
    tbl.push_back(mk(1, 4'b0100, 0, 0, 2'd0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 1, 2'd2, 4'b0100, 1, 0));
    tbl.push_back(mk(8, 4'b0000, 1, 0, 2'd2, 4'b0100, 1, 0));
    tbl.push_back(mk(1, 4'b1000, 1, 0, 2'd2, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd2, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 2'd3, 4'b1000, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 2'd3, 4'b1000, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd3, 4'b1000, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 1, 2'd0, 4'b0001, 1, 1));
    tbl.push_back(mk(2, 4'b0000, 1, 0, 2'd0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 2'd0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 2'd0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 4'b0001, 1, 1));
    tbl.push_back(mk(24, 4'b0000, 1, 0, 2'd0, 4'b0001, 1, 0));
    tbl.push_back(mk(2, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 2'd2, 4'b0100, 1, 0));
    tbl.push_back(mk(8, 4'b0000, 1, 0, 2'd2, 4'b0100, 1, 0));
    tbl.push_back(mk(6, 4'b0000, 1, 0, 2'd2, 4'b0000, 0, 0));

    reset = 1'b1;
    ifa.req = 4'b0000; ifa.frame_end = 1'b0;
    ifb.req = 4'b0000; ifb.frame_end = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", outa, 9'b0);
    chk("reset_b", outb, 9'b0);

    // Zero duration and zero gap: one-frame play, IDLE right after GAP
    reset = 1'b0;
    ifb.req = 4'b1000;                                   chk("b0", outb, {1'b0, 2'd0, 4'b0000, 1'b0, 1'b0});
    @(negedge clk); ifb.req = 4'b0000;                   chk("b1", outb, {1'b0, 2'd0, 4'b0000, 1'b0, 1'b0});
    @(negedge clk); ifb.frame_end = 1'b1;                chk("b2", outb, {1'b1, 2'd3, 4'b1000, 1'b1, 1'b0});
    @(negedge clk); ifb.req = 4'b0001;                   chk("b3", outb, {1'b0, 2'd3, 4'b1000, 1'b1, 1'b0});
    @(negedge clk); ifb.req = 4'b0000;                   chk("b4", outb, {1'b0, 2'd3, 4'b0000, 1'b0, 1'b0});
    @(negedge clk); ifb.frame_end = 1'b0;                chk("b5", outb, {1'b0, 2'd3, 4'b0000, 1'b0, 1'b0});
    @(negedge clk);                                      chk("b6", outb, {1'b1, 2'd0, 4'b0001, 1'b1, 1'b0});

    // Vector table on the default instance, one check per cycle
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        @(negedge clk);
        ifa.req = tbl[i].req;
        ifa.frame_end = tbl[i].fe;
        chk($sformatf("vec%0d.%0d", i, r), outa, tbl[i].exp);
      end
    end

    // Simultaneous edges on 3 and 1: effect 1 first, effect 3 after its gap
    ntrig = 0; t1 = -1; t2 = -1; vs1 = -1; vs2 = -1; g1 = -1; ndrop = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      ifa.req = (t == 0) ? 4'b1010 : 4'b0000;
      ifa.frame_end = 1'b1;
      if (ifa.dropped) ndrop++;
      if (ifa.trigger) begin
        ntrig++;
        if (ntrig == 1) begin t1 = t; vs1 = int'(ifa.voice_sel); g1 = int'(ifa.grant); end
        if (ntrig == 2) begin t2 = t; vs2 = int'(ifa.voice_sel); end
      end
    end
    chki("prio_ntrig", ntrig, 2);
    chki("prio_t1", t1, 2);
    chki("prio_vs1", vs1, 1);
    chki("prio_g1", g1, 2);
    chki("prio_t2", t2, 22);
    chki("prio_vs2", vs2, 3);
    chki("prio_dropped", ndrop, 0);

    // Reset during PLAY with req[1] held across it; pending req[3] is lost
    ntrig = 0; t1 = -1; vs1 = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      ifa.frame_end = 1'b0;
      reset = (t == 5);
      case (t)
        0:       ifa.req = 4'b0100;
        3:       ifa.req = 4'b1000;
        1, 2, 4: ifa.req = 4'b0000;
        15:      ifa.req = 4'b0000;
        default: ifa.req = 4'b0010;
      endcase
      if (t == 4) chk("rst_before", outa, {1'b0, 2'd2, 4'b0100, 1'b1, 1'b0});
      if (t == 6) chk("rst_after", outa, 9'b0);
      if (t >= 6 && ifa.trigger) begin
        ntrig++;
        if (ntrig == 1) begin t1 = t; vs1 = int'(ifa.voice_sel); end
      end
    end
    reset = 1'b0;
    chki("rst_ntrig", ntrig, 1);
    chki("rst_trig_t", t1, 18);
    chki("rst_trig_vs", vs1, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
